// File: rtl/pic_bus_sequencer.sv
// 8259 data bus buffer sequencer: strobe synchronizers, CPU read/write enables, INTA pulse FSM.
// Optional PIC_POLL_EN macro adds poll-mode reads. dbg_state encoding: 0=IDLE 1=P1 2=G1 3=P2 4=G2 5=P3.
module pic_bus_sequencer #(
  parameter int INTA_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       inta_n,
  input  logic       a0,
  input  logic       mode_8086,
  input  logic       read_isr,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  input  logic [7:0] imr,
  input  logic [7:0] vector,
  input  logic [7:0] addr_lo,
  input  logic [7:0] addr_hi,
`ifdef PIC_POLL_EN
  input  logic       poll,
  input  logic [2:0] poll_level,
  input  logic       int_pending,
`endif
  output logic       bus_r,
  output logic       bus_w,
  output logic [7:0] internal_out,
  output logic       internal_oe,
  output logic       wr_pulse,
  output logic       wr_a0,
  output logic       freeze,
  output logic       isr_set,
  output logic       inta_abort,
  output logic [2:0] dbg_state
);

  // Handshake: strobes are level-sensitive CPU pins; every output is registered and
  // follows a synchronized strobe edge two clk edges after it is first sampled.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    G1   = 3'd2,
    P2   = 3'd3,
    G2   = 3'd4,
    P3   = 3'd5
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(INTA_TIMEOUT);
  // Bit order {a0, inta_n, wr_n, rd_n, cs_n}; strobes rest high so reset looks idle.
  localparam logic [4:0]      SYNC_RST = 5'b01111;

  logic [4:0]      sync1_q, sync2_q;
  state_t          state_q;
  logic            mode_q;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            bus_r_q, bus_w_q, oe_q;
  logic [7:0]      out_q;
  logic            wr_pulse_q, wr_a0_q, freeze_q, isr_set_q, inta_abort_q;
  logic [7:0]      rd_byte;
  logic            cs_s, rd_s, wr_s, inta_s, a0_s;
  logic            rd_act, wr_act, inta_act;
`ifdef PIC_POLL_EN
  logic            pend_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= {a0, inta_n, wr_n, rd_n, cs_n};
      sync2_q <= sync1_q;
    end
  end

  assign cs_s     = sync2_q[0];
  assign rd_s     = sync2_q[1];
  assign wr_s     = sync2_q[2];
  assign inta_s   = sync2_q[3];
  assign a0_s     = sync2_q[4];
  // Simultaneous rd and wr is treated as neither.
  assign rd_act   = ~cs_s & ~rd_s & wr_s;
  assign wr_act   = ~cs_s & ~wr_s & rd_s;
  assign inta_act = ~inta_s;
  assign to_cnt_d = to_cnt_q + TO_W'(1);

  always_comb begin
    rd_byte = a0_s ? imr : (read_isr ? isr : irr);
`ifdef PIC_POLL_EN
    if (poll) rd_byte = {int_pending, 4'b0000, poll_level};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      to_cnt_q     <= '0;
      bus_r_q      <= 1'b0;
      bus_w_q      <= 1'b0;
      oe_q         <= 1'b0;
      out_q        <= 8'h00;
      wr_pulse_q   <= 1'b0;
      wr_a0_q      <= 1'b0;
      freeze_q     <= 1'b0;
      isr_set_q    <= 1'b0;
      inta_abort_q <= 1'b0;
`ifdef PIC_POLL_EN
      pend_q       <= 1'b0;
`endif
    end else begin
      wr_pulse_q   <= 1'b0;
      isr_set_q    <= 1'b0;
      inta_abort_q <= 1'b0;
      to_cnt_q     <= '0;
      case (state_q)
        IDLE: begin
          if (inta_act) begin
            // INTA wins over any CPU access in flight; a cut-short write gives no pulse.
            state_q   <= P1;
            freeze_q  <= 1'b1;
            isr_set_q <= 1'b1;
            mode_q    <= mode_8086;
            bus_w_q   <= 1'b0;
            bus_r_q   <= ~mode_8086;
            oe_q      <= ~mode_8086;
            out_q     <= mode_8086 ? 8'h00 : 8'hCD;
          end else if (rd_act) begin
            bus_r_q <= 1'b1;
            bus_w_q <= 1'b0;
            oe_q    <= 1'b1;
            out_q   <= rd_byte;
          end else if (wr_act) begin
            if (!bus_w_q) wr_a0_q <= a0_s;
            bus_w_q <= 1'b1;
            bus_r_q <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 8'h00;
          end else begin
            wr_pulse_q <= bus_w_q & wr_s;
            bus_w_q    <= 1'b0;
            bus_r_q    <= 1'b0;
            oe_q       <= 1'b0;
            out_q      <= 8'h00;
          end
`ifdef PIC_POLL_EN
          if (rd_act && !inta_act) begin
            pend_q <= poll & int_pending;
          end else begin
            pend_q <= 1'b0;
            if (!inta_act && pend_q) isr_set_q <= 1'b1;
          end
`endif
        end
        P1: begin
          if (!inta_act) begin
            state_q <= G1;
            bus_r_q <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 8'h00;
          end
        end
        G1: begin
          if (inta_act) begin
            state_q <= P2;
            bus_r_q <= 1'b1;
            oe_q    <= 1'b1;
            out_q   <= mode_q ? vector : addr_lo;
          end else if (to_cnt_d == TO_LIM) begin
            state_q      <= IDLE;
            freeze_q     <= 1'b0;
            inta_abort_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        P2: begin
          if (!inta_act) begin
            bus_r_q <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 8'h00;
            if (mode_q) begin
              state_q  <= IDLE;
              freeze_q <= 1'b0;
            end else begin
              state_q <= G2;
            end
          end else begin
            out_q <= mode_q ? vector : addr_lo;
          end
        end
        G2: begin
          if (inta_act) begin
            state_q <= P3;
            bus_r_q <= 1'b1;
            oe_q    <= 1'b1;
            out_q   <= addr_hi;
          end else if (to_cnt_d == TO_LIM) begin
            state_q      <= IDLE;
            freeze_q     <= 1'b0;
            inta_abort_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        P3: begin
          if (!inta_act) begin
            state_q  <= IDLE;
            freeze_q <= 1'b0;
            bus_r_q  <= 1'b0;
            oe_q     <= 1'b0;
            out_q    <= 8'h00;
          end else begin
            out_q <= addr_hi;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_r        = bus_r_q;
  assign bus_w        = bus_w_q;
  assign internal_out = out_q;
  assign internal_oe  = oe_q;
  assign wr_pulse     = wr_pulse_q;
  assign wr_a0        = wr_a0_q;
  assign freeze       = freeze_q;
  assign isr_set      = isr_set_q;
  assign inta_abort   = inta_abort_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pic_bus_sequencer.sv
// Directed-plus-random bench for pic_bus_sequencer; expectations come from the pin-level
// behaviour (two-edge strobe latency, byte order per INTA mode, gap timeout length).
module tb_pic_bus_sequencer;

  localparam int TIMEOUT = 64;

  logic       clk, reset, cs_n, rd_n, wr_n, inta_n, a0, mode_8086, read_isr;
  logic [7:0] irr, isr, imr, vector, addr_lo, addr_hi;
  logic       bus_r, bus_w, internal_oe, wr_pulse, wr_a0, freeze, isr_set, inta_abort;
  logic [7:0] internal_out;
  logic [2:0] dbg_state;
`ifdef PIC_POLL_EN
  logic       poll, int_pending;
  logic [2:0] poll_level;
`endif

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int isr_cnt = 0;
  int abort_cnt = 0;

  pic_bus_sequencer #(.INTA_TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .inta_n(inta_n),
    .a0(a0), .mode_8086(mode_8086), .read_isr(read_isr), .irr(irr), .isr(isr), .imr(imr),
    .vector(vector), .addr_lo(addr_lo), .addr_hi(addr_hi),
`ifdef PIC_POLL_EN
    .poll(poll), .poll_level(poll_level), .int_pending(int_pending),
`endif
    .bus_r(bus_r), .bus_w(bus_w), .internal_out(internal_out), .internal_oe(internal_oe),
    .wr_pulse(wr_pulse), .wr_a0(wr_a0), .freeze(freeze), .isr_set(isr_set),
    .inta_abort(inta_abort), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pulse counters and bus invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_pulse === 1'b1) wr_cnt++;
      if (isr_set === 1'b1) isr_cnt++;
      if (inta_abort === 1'b1) abort_cnt++;
      chk1("excl_r_w", bus_r & bus_w, 1'b0);
      chk1("w_oe", bus_w & internal_oe, 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] rd_model();
    return a0 ? imr : (read_isr ? isr : irr);
  endfunction

  task automatic check_reset(input string tag);
    chk1({tag, "_bus_r"}, bus_r, 1'b0);
    chk1({tag, "_bus_w"}, bus_w, 1'b0);
    chk1({tag, "_oe"}, internal_oe, 1'b0);
    chk8({tag, "_out"}, internal_out, 8'h00);
    chk1({tag, "_wr_pulse"}, wr_pulse, 1'b0);
    chk1({tag, "_wr_a0"}, wr_a0, 1'b0);
    chk1({tag, "_freeze"}, freeze, 1'b0);
    chk1({tag, "_isr_set"}, isr_set, 1'b0);
    chk1({tag, "_abort"}, inta_abort, 1'b0);
    chki({tag, "_state"}, int'(dbg_state), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset("rst");
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
  endtask

  // driver: CPU read held low for hold (>=4) edges
  task automatic do_read(input logic a0v, input logic sel, input logic [7:0] v_irr,
                         input logic [7:0] v_isr, input logic [7:0] v_imr, input int hold);
    int w0, i0;
    w0 = wr_cnt; i0 = isr_cnt;
    irr = v_irr; isr = v_isr; imr = v_imr; a0 = a0v; read_isr = sel;
    cs_n = 1'b0; rd_n = 1'b0;
    tick(1); chk1("rd_lat_n", bus_r, 1'b0);
    tick(1); chk1("rd_lat_n1", bus_r, 1'b0);
    tick(1); chk1("rd_on", bus_r, 1'b1);
    chk1("rd_oe", internal_oe, 1'b1);
    chk1("rd_bus_w", bus_w, 1'b0);
    chk8("rd_byte", internal_out, rd_model());
    irr = 8'($urandom); isr = 8'($urandom); imr = 8'($urandom);
    tick(1); chk8("rd_live", internal_out, rd_model());
    tick(hold - 4);
    rd_n = 1'b1; cs_n = 1'b1;
    tick(2); chk1("rd_rel_lat", bus_r, 1'b1);
    tick(1); chk1("rd_off", bus_r, 1'b0);
    chk1("rd_off_oe", internal_oe, 1'b0);
    chki("rd_no_wr_pulse", wr_cnt - w0, 0);
    chki("rd_no_isr_set", isr_cnt - i0, 0);
  endtask

  // driver: CPU write held low for hold (>=3) edges; a0 is flipped mid-write
  task automatic do_write(input logic a0v, input int hold);
    int w0;
    w0 = wr_cnt;
    a0 = a0v; cs_n = 1'b0; wr_n = 1'b0;
    tick(1); chk1("wr_lat_n", bus_w, 1'b0);
    tick(1); chk1("wr_lat_n1", bus_w, 1'b0);
    tick(1); chk1("wr_on", bus_w, 1'b1);
    chk1("wr_oe", internal_oe, 1'b0);
    chk1("wr_bus_r", bus_r, 1'b0);
    a0 = ~a0v;
    repeat (hold - 3) begin
      tick(1);
      chk1("wr_hold", bus_w, 1'b1);
      chk1("wr_hold_pulse", wr_pulse, 1'b0);
    end
    wr_n = 1'b1;
    tick(2); chk1("wr_rel_lat", bus_w, 1'b1);
    chk1("wr_rel_pulse", wr_pulse, 1'b0);
    tick(1); chk1("wr_pulse", wr_pulse, 1'b1);
    chk1("wr_end_bus_w", bus_w, 1'b0);
    chk1("wr_a0", wr_a0, a0v);
    chk1("wr_end_bus_r", bus_r, 1'b0);
    tick(1); chk1("wr_pulse_once", wr_pulse, 1'b0);
    chki("wr_pulse_cnt", wr_cnt - w0, 1);
    cs_n = 1'b1;
    tick(2);
  endtask

  // driver + scoreboard: a full INTA sequence
  task automatic inta_seq(input logic m86, input int low_c, input int gap_c, input bit rd_in_gap);
    logic [7:0] exp_q[$];
    bit         drv_q[$];
    int         n, i0, ab0;
    logic [7:0] b;
    bit         d;
    i0 = isr_cnt; ab0 = abort_cnt;
    mode_8086 = m86;
    if (m86) begin
      drv_q = '{1'b0, 1'b1};
      exp_q.push_back(8'h00); exp_q.push_back(vector);
    end else begin
      drv_q = '{1'b1, 1'b1, 1'b1};
      exp_q.push_back(8'hCD); exp_q.push_back(addr_lo); exp_q.push_back(addr_hi);
    end
    n = drv_q.size();
    for (int p = 0; p < n; p++) begin
      b = exp_q.pop_front();
      d = drv_q.pop_front();
      inta_n = 1'b0;
      tick(2);
      chk1("inta_pre_freeze", freeze, p > 0);
      chk1("inta_pre_bus_r", bus_r, 1'b0);
      tick(1);
      chk1("inta_freeze", freeze, 1'b1);
      chk1("inta_bus_r", bus_r, d);
      chk1("inta_oe", internal_oe, d);
      chk1("inta_isr_set", isr_set, p == 0);
      if (d) chk8("inta_byte", internal_out, b);
      if (p == 0) mode_8086 = ~m86;
      repeat (low_c - 3) begin
        tick(1);
        chk1("inta_isr_once", isr_set, 1'b0);
        chk1("inta_hold_bus_r", bus_r, d);
      end
      inta_n = 1'b1;
      tick(2); chk1("inta_rel_lat", bus_r, d);
      tick(1);
      chk1("inta_gap_bus_r", bus_r, 1'b0);
      chk1("inta_gap_oe", internal_oe, 1'b0);
      chk1("inta_gap_freeze", freeze, p < n - 1);
      if (p < n - 1) begin
        if (rd_in_gap) begin
          cs_n = 1'b0; rd_n = 1'b0;
          repeat (gap_c) begin
            tick(1);
            chk1("inta_gap_rd_ignored", bus_r, 1'b0);
          end
          cs_n = 1'b1; rd_n = 1'b1;
        end else begin
          tick(gap_c);
        end
      end
    end
    chki("inta_isr_cnt", isr_cnt - i0, 1);
    chki("inta_no_abort", abort_cnt - ab0, 0);
    chki("inta_end_state", int'(dbg_state), 0);
    tick(2);
  endtask

  // driver: npulse INTA pulses, then inta_n held high until the gap times out
  task automatic timeout_seq(input logic m86, input int npulse);
    int ab0, i;
    ab0 = abort_cnt;
    mode_8086 = m86;
    for (int p = 0; p < npulse; p++) begin
      inta_n = 1'b0;
      tick(4);
      inta_n = 1'b1;
      if (p < npulse - 1) tick(4);
    end
    tick(1);
    i = 0;
    while (inta_abort !== 1'b1 && i < 3 * TIMEOUT) begin
      tick(1);
      i++;
      if (i < TIMEOUT) chk1("to_freeze_held", freeze, 1'b1);
    end
    chki("to_latency", i, TIMEOUT + 2);
    chk1("to_freeze", freeze, 1'b0);
    chk1("to_bus_r", bus_r, 1'b0);
    chki("to_state", int'(dbg_state), 0);
    tick(1);
    chk1("to_abort_once", inta_abort, 1'b0);
    chki("to_abort_cnt", abort_cnt - ab0, 1);
  endtask

  initial begin
    int w0, ab0;
    reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1;
    a0 = 1'b0; mode_8086 = 1'b1; read_isr = 1'b0;
    irr = 8'h00; isr = 8'h00; imr = 8'h00; vector = 8'h00; addr_lo = 8'h00; addr_hi = 8'h00;
`ifdef PIC_POLL_EN
    poll = 1'b0; poll_level = 3'd0; int_pending = 1'b0;
`endif
    tick(3);
    check_reset("reset");
    reset = 1'b0;
    tick(3);
    check_reset("post_reset");

    // directed reads, then random ones
    do_read(1'b0, 1'b0, 8'h11, 8'($urandom), 8'($urandom), 6);
    do_read(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'hAA, 6);
    do_read(1'b0, 1'b1, 8'($urandom), 8'h5C, 8'($urandom), 5);
    repeat (4) do_read(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       $urandom_range(4, 8));

    // reset in the middle of a read
    w0 = wr_cnt;
    cs_n = 1'b0; rd_n = 1'b0;
    tick(3);
    chk1("rst_mid_rd_active", bus_r, 1'b1);
    do_reset();
    chk1("rst_mid_rd_bus_r", bus_r, 1'b0);
    chki("rst_mid_rd_no_wr", wr_cnt - w0, 0);
    chk1("rst_mid_rd_no_isr", isr_set, 1'b0);

    // writes
    do_write(1'b1, 5);
    do_write(1'b0, 5);
    repeat (3) do_write(1'($urandom), $urandom_range(3, 7));

    // rd and wr both low
    w0 = wr_cnt;
    cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    tick(4);
    chk1("both_low_bus_r", bus_r, 1'b0);
    chk1("both_low_bus_w", bus_w, 1'b0);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    tick(4);
    chki("both_low_no_pulse", wr_cnt - w0, 0);

    // INTA sequences
    vector = 8'h4B;
    inta_seq(1'b1, 4, 5, 1'b0);
    addr_lo = 8'h20; addr_hi = 8'h01;
    inta_seq(1'b0, 3, 6, 1'b1);
    repeat (6) begin
      vector = 8'($urandom); addr_lo = 8'($urandom); addr_hi = 8'($urandom);
      inta_seq(1'($urandom), $urandom_range(3, 6), $urandom_range(2, 20), bit'($urandom));
    end

    // gap timeouts in G1 (both modes) and G2
    timeout_seq(1'b1, 1);
    timeout_seq(1'b0, 1);
    timeout_seq(1'b0, 2);

    // INTA arriving during a read
    mode_8086 = 1'b1; a0 = 1'b0; read_isr = 1'b0;
    w0 = wr_cnt; ab0 = abort_cnt;
    cs_n = 1'b0; rd_n = 1'b0;
    tick(3);
    chk1("conf_rd_active", bus_r, 1'b1);
    inta_n = 1'b0;
    tick(2); chk1("conf_rd_lat", bus_r, 1'b1);
    tick(1);
    chk1("conf_rd_dropped", bus_r, 1'b0);
    chk1("conf_rd_oe", internal_oe, 1'b0);
    chk1("conf_rd_freeze", freeze, 1'b1);
    chk1("conf_rd_isr_set", isr_set, 1'b1);
    cs_n = 1'b1; rd_n = 1'b1;
    tick(3);
    chki("conf_rd_no_wr", wr_cnt - w0, 0);
    do_reset();
    chki("rst_mid_inta_no_abort", abort_cnt - ab0, 0);

    // INTA arriving during a write
    w0 = wr_cnt;
    a0 = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    tick(3);
    chk1("conf_wr_active", bus_w, 1'b1);
    inta_n = 1'b0;
    tick(3);
    chk1("conf_wr_dropped", bus_w, 1'b0);
    chk1("conf_wr_freeze", freeze, 1'b1);
    wr_n = 1'b1; cs_n = 1'b1;
    tick(4);
    chki("conf_wr_no_pulse", wr_cnt - w0, 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_bus_sequencer.md
Name: pic_bus_sequencer

Overview:
- Control/sequencing block for the 8259 data bus buffer. It synchronizes the CPU strobes (cs_n, rd_n, wr_n, inta_n) to clk and generates the buffer's `r`/`w` enables.
- It arbitrates the internal bus between status reads and interrupt-acknowledge vector output.
- It runs the INTA pulse state machine: 2 pulses in 8086 mode, 3 pulses in 8080 mode.
- It sits between the CPU pins, the data bus buffer, and the priority resolver / ISR logic.

Parameters:
- INTA_TIMEOUT, default 64: clk cycles allowed between INTA pulses before the sequence is aborted.
- TO_W, default 7: timeout counter width; must hold INTA_TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cs_n  in  1  chip select, active low
- rd_n  in  1  read strobe, active low
- wr_n  in  1  write strobe, active low
- inta_n  in  1  interrupt acknowledge, active low
- a0  in  1  CPU address bit 0
- mode_8086  in  1  ICW4 uPM: 1 = 8086, 0 = 8080
- read_isr  in  1  OCW3 select: 1 = ISR, 0 = IRR
- irr  in  8  interrupt request register
- isr  in  8  in-service register
- imr  in  8  interrupt mask register
- vector  in  8  8086 vector byte from the resolver
- addr_lo  in  8  8080 CALL address low byte
- addr_hi  in  8  8080 CALL address high byte
- bus_r  out  1  to buffer `r`: drive internal onto data
- bus_w  out  1  to buffer `w`: pass data onto internal
- internal_out  out  8  byte presented on the internal bus
- internal_oe  out  1  internal bus driven by this block; 0 = released (z)
- wr_pulse  out  1  one-cycle pulse at end of a CPU write
- wr_a0  out  1  a0 latched at write start, valid with wr_pulse
- freeze  out  1  high for the whole INTA sequence
- isr_set  out  1  one-cycle pulse: set ISR bit of the highest-priority request
- inta_abort  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: all outputs 0, internal_out = 8'h00, FSM = IDLE, timeout counter = 0. Reset mid-sequence aborts immediately without an inta_abort pulse.
- Strobes pass through 2-flop synchronizers, then output registers. A strobe first sampled low at edge N yields its outputs at edge N+2. Release has the same latency.
- FSM states: IDLE, P1, G1, P2, G2, P3.
- IDLE → P1 on synced inta_n low, regardless of cs_n. Entering P1: freeze = 1 and isr_set pulses.
  - 8086 in P1: internal_oe = 0, bus_r = 0.
  - 8080 in P1: drive 8'hCD with bus_r = 1.
- P1 → G1 on synced inta_n high; bus_r = 0, internal_oe = 0.
- G1 → P2 on synced inta_n low. P2 drives `vector` (8086) or `addr_lo` (8080) with bus_r = 1.
- P2 release:
  - 8086: → IDLE, freeze = 0.
  - 8080: → G2.
- G2 → P3 on synced inta_n low. P3 drives `addr_hi`; on release → IDLE, freeze = 0.
- G1/G2 timeout:
  - The counter increments each cycle in G1/G2 and clears on any state change.
  - At INTA_TIMEOUT: → IDLE, inta_abort pulses, freeze = 0.
- mode_8086 is sampled on entry to P1 and held for the sequence.
- CPU read: in IDLE with synced cs_n = 0 and rd_n = 0, set bus_r = 1 and internal_oe = 1. internal_out is selected as:
  - a0 = 1: imr.
  - a0 = 0: isr if read_isr = 1, else irr.
  - internal_out tracks its source live while the read is active.
- CPU write: in IDLE with synced cs_n = 0 and wr_n = 0, set bus_w = 1 and internal_oe = 0. a0 is latched at write start into wr_a0. On synced wr_n rising, wr_pulse fires for 1 cycle and bus_w drops the same cycle.
- Conflicts:
  - rd_n and wr_n both low: neither bus_r nor bus_w is asserted.
  - INTA has priority: inta_n low in IDLE during a read/write terminates it next cycle (no wr_pulse) and starts P1.
  - rd/wr strobes are ignored outside IDLE.
- bus_r and bus_w are never high together. internal_oe = 0 whenever bus_w = 1.

Optional Feature:
- Macro: PIC_POLL_EN.
- When defined:
  - Adds inputs `poll` (1, OCW3 P bit) and `poll_level` (3), and `int_pending` (1).
  - A CPU read with poll = 1 returns {int_pending, 4'b0000, poll_level}, overriding the a0 selection.
  - isr_set pulses at read completion if int_pending was 1.
- When undefined: these ports do not exist and reads behave as above.

Test Plan:
- Reset mid-read: reset asserted while bus_r = 1 → bus_r = 0, internal_oe = 0, FSM IDLE; no stray wr_pulse or isr_set.
- IRR/IMR read:
  - irr = 8'h11, read_isr = 0, a0 = 0, cs_n = 0, rd_n low 6 cycles → bus_r = 1 from edge N+2, internal_out = 8'h11.
  - Same with a0 = 1, imr = 8'hAA → internal_out = 8'hAA.
- Write: cs_n = 0, a0 = 1, wr_n low 5 cycles → bus_w = 1 from edge N+2. On release: wr_pulse exactly 1 cycle, wr_a0 = 1; bus_r stays 0 throughout.
- 8086 INTA: mode_8086 = 1, vector = 8'h4B, two inta_n pulses →
  - P1: isr_set pulses once, freeze = 1, bus released.
  - P2: internal_out = 8'h4B with bus_r = 1.
  - freeze = 0 after the second release.
- 8080 INTA: three pulses, addr_lo = 8'h20, addr_hi = 8'h01 → bytes CD, 20, 01 on consecutive pulses; bus_r = 0 in the gaps.
- Timeout and conflict:
  - One INTA pulse, then inta_n held high 64 cycles → inta_abort pulse, FSM IDLE, freeze = 0.
  - inta_n falls during an active read → bus_r drops, P1 entered, no wr_pulse.
